// File: rtl/clock_set_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clock_set_controller_pkg
//  Purpose  : Shared encodings for the clock/calendar set controller:
//             FSM states, field indices, per-field value ranges and
//             small helper functions used by the controller and counters.
//  Revision : 1.0 - initial release
// ============================================================================
package clock_set_controller_pkg;

    // Set-mode FSM states; SET_* order matches the field order on the bus.
    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_SET_HOUR  = 3'd1,
        ST_SET_MIN   = 3'd2,
        ST_SET_DAY   = 3'd3,
        ST_SET_DATE  = 3'd4,
        ST_SET_MONTH = 3'd5
    } state_t;

    // Field indices: also the bit position in the one-hot databus enable.
    localparam int         c_NUM_FIELDS = 5;
    localparam logic [2:0] c_F_HOUR     = 3'd0;
    localparam logic [2:0] c_F_MIN      = 3'd1;
    localparam logic [2:0] c_F_DAY      = 3'd2;
    localparam logic [2:0] c_F_DATE     = 3'd3;
    localparam logic [2:0] c_F_MONTH    = 3'd4;

    // Legal value ranges of each counter (date is 1-31 regardless of month).
    localparam logic [5:0] c_HOUR_MIN  = 6'd0;
    localparam logic [5:0] c_HOUR_MAX  = 6'd23;
    localparam logic [5:0] c_MIN_MIN   = 6'd0;
    localparam logic [5:0] c_MIN_MAX   = 6'd59;
    localparam logic [5:0] c_DAY_MIN   = 6'd1;
    localparam logic [5:0] c_DAY_MAX   = 6'd7;
    localparam logic [5:0] c_DATE_MIN  = 6'd1;
    localparam logic [5:0] c_DATE_MAX  = 6'd31;
    localparam logic [5:0] c_MONTH_MIN = 6'd1;
    localparam logic [5:0] c_MONTH_MAX = 6'd12;

    // Lowest legal value of a field.
    function automatic logic [5:0] field_min(input logic [2:0] f);
        case (f)
            c_F_HOUR:  return c_HOUR_MIN;
            c_F_MIN:   return c_MIN_MIN;
            c_F_DAY:   return c_DAY_MIN;
            c_F_DATE:  return c_DATE_MIN;
            c_F_MONTH: return c_MONTH_MIN;
            default:   return 6'd0;
        endcase
    endfunction

    // Highest legal value of a field.
    function automatic logic [5:0] field_max(input logic [2:0] f);
        case (f)
            c_F_HOUR:  return c_HOUR_MAX;
            c_F_MIN:   return c_MIN_MAX;
            c_F_DAY:   return c_DAY_MAX;
            c_F_DATE:  return c_DATE_MAX;
            c_F_MONTH: return c_MONTH_MAX;
            default:   return 6'd0;
        endcase
    endfunction

    // Wrap-around increment; anything at or above the maximum, or below the
    // minimum (a corrupt live value), lands on the field minimum.
    function automatic logic [5:0] incr_wrap(input logic [2:0] f, input logic [5:0] v);
        logic [5:0] lo;
        logic [5:0] hi;
        lo = field_min(f);
        hi = field_max(f);
        if ((v < lo) || (v >= hi)) begin
            return lo;
        end
        return v + 6'd1;
    endfunction

    // One-hot databus enable / load strobe vector for a field index.
    function automatic logic [4:0] field_onehot(input logic [2:0] f);
        return 5'b00001 << f;
    endfunction

    // Field edited in a given SET_* state (RUN maps to hour, never used).
    function automatic logic [2:0] state_field(input state_t s);
        case (s)
            ST_SET_HOUR:  return c_F_HOUR;
            ST_SET_MIN:   return c_F_MIN;
            ST_SET_DAY:   return c_F_DAY;
            ST_SET_DATE:  return c_F_DATE;
            ST_SET_MONTH: return c_F_MONTH;
            default:      return c_F_HOUR;
        endcase
    endfunction

    // Successor state on a mode press: RUN -> hour -> ... -> month -> RUN.
    function automatic state_t next_state(input state_t s);
        case (s)
            ST_RUN:       return ST_SET_HOUR;
            ST_SET_HOUR:  return ST_SET_MIN;
            ST_SET_MIN:   return ST_SET_DAY;
            ST_SET_DAY:   return ST_SET_DATE;
            ST_SET_DATE:  return ST_SET_MONTH;
            ST_SET_MONTH: return ST_RUN;
            default:      return ST_RUN;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_set_controller_field_scan.sv
`default_nettype none
// ============================================================================
//  Module   : clock_set_controller_field_scan
//  Purpose  : RUN-mode databus scanner. Holds each field's one-hot enable for
//             SCAN_DIV cycles, then rotates hour->min->day->date->month->hour.
//             A synchronous restart parks the scanner on hour with the
//             divider cleared.
//  Revision : 1.0 - initial release
// ============================================================================
module clock_set_controller_field_scan
    import clock_set_controller_pkg::*;
#(
    parameter int SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       restart,
    output logic [4:0] field_en
);

    localparam int                 c_CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SCAN_DIV - 1);

    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_NUM_FIELDS-1:0] r_onehot;

    // Divider and rotator: rotate once every SCAN_DIV cycles, park on restart.
    always_ff @(posedge clk) begin
        if (!clear || restart) begin
            r_cnt    <= '0;
            r_onehot <= 5'b00001;
        end else if (r_cnt == c_CNT_LAST) begin
            r_cnt    <= '0;
            r_onehot <= {r_onehot[c_NUM_FIELDS-2:0], r_onehot[c_NUM_FIELDS-1]};
        end else begin
            r_cnt    <= r_cnt + c_CNT_W'(1);
        end
    end

    assign field_en = r_onehot;

endmodule
`default_nettype wire

// File: rtl/clock_set_controller.sv
`default_nettype none
// ============================================================================
//  Module   : clock_set_controller
//  Purpose  : Time/date set-mode controller and databus scheduler for the
//             hour/minute/day/date/month counter chain. Two debounced
//             buttons walk a set-mode FSM; each field's edit value is
//             committed to its counter with a one-cycle load strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module clock_set_controller
    import clock_set_controller_pkg::*;
#(
    parameter int SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [2:0] cur_day,
    input  logic [4:0] cur_date,
    input  logic [3:0] cur_month,
    output logic       load_hour,
    output logic       load_min,
    output logic       load_day,
    output logic       load_date,
    output logic       load_month,
    output logic [5:0] load_data,
    output logic [4:0] field_en,
    output logic       run_en,
    output logic       setting,
    output logic [5:0] edit_val
);

    state_t     r_state;
    logic       r_mode_q;
    logic       r_inc_q;
    logic [4:0] r_load;
    logic [5:0] r_load_data;
    logic [5:0] r_edit;
    logic       r_run_en;
    logic       r_setting;
    logic [4:0] r_set_field_en;

    logic       w_press_mode;
    logic       w_press_inc;
    state_t     w_next_state;
    logic [2:0] w_cur_field;
    logic [2:0] w_next_field;
    logic [5:0] w_seed;
    logic [4:0] w_scan_en;

    // Rising-edge detect on the already-debounced buttons.
    assign w_press_mode = mode_btn & ~r_mode_q;
    assign w_press_inc  = inc_btn  & ~r_inc_q;

    assign w_next_state = next_state(r_state);
    assign w_cur_field  = state_field(r_state);
    assign w_next_field = state_field(w_next_state);

    // Live value of the field about to be edited, zero-extended to 6 bits.
    always_comb begin
        w_seed = 6'd0;
        case (w_next_field)
            c_F_HOUR:  w_seed = {1'b0, cur_hour};
            c_F_MIN:   w_seed = cur_min;
            c_F_DAY:   w_seed = {3'b000, cur_day};
            c_F_DATE:  w_seed = {1'b0, cur_date};
            c_F_MONTH: w_seed = {2'b00, cur_month};
            default:   w_seed = 6'd0;
        endcase
    end

    // Scanner is held parked while setting so RUN always resumes on hour.
    clock_set_controller_field_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_field_scan (
        .clk      (clk),
        .clear    (clear),
        .restart  (r_setting),
        .field_en (w_scan_en)
    );

    // Set-mode FSM: button edges, edit value, commit strobes, mode outputs.
    always_ff @(posedge clk) begin
        if (!clear) begin
            r_state        <= ST_RUN;
            r_mode_q       <= 1'b0;
            r_inc_q        <= 1'b0;
            r_load         <= 5'b00000;
            r_load_data    <= 6'd0;
            r_edit         <= 6'd0;
            r_run_en       <= 1'b1;
            r_setting      <= 1'b0;
            r_set_field_en <= 5'b00001;
        end else begin
            r_mode_q <= mode_btn;
            r_inc_q  <= inc_btn;
            r_load   <= 5'b00000;

            // Mode has priority: a simultaneous inc press is dropped.
            if (w_press_mode) begin
                r_state        <= w_next_state;
                r_setting      <= (w_next_state != ST_RUN);
                r_run_en       <= (w_next_state == ST_RUN);
                r_set_field_en <= field_onehot(w_next_field);
                if (r_state != ST_RUN) begin
                    r_load      <= field_onehot(w_cur_field);
                    r_load_data <= r_edit;
                end
                if (w_next_state != ST_RUN) begin
                    r_edit <= w_seed;
                end
            end else if (w_press_inc && (r_state != ST_RUN)) begin
                r_edit <= incr_wrap(w_cur_field, r_edit);
            end
        end
    end

    assign load_hour  = r_load[c_F_HOUR];
    assign load_min   = r_load[c_F_MIN];
    assign load_day   = r_load[c_F_DAY];
    assign load_date  = r_load[c_F_DATE];
    assign load_month = r_load[c_F_MONTH];
    assign load_data  = r_load_data;
    assign field_en   = r_setting ? r_set_field_en : w_scan_en;
    assign run_en     = r_run_en;
    assign setting    = r_setting;
    assign edit_val   = r_edit;

endmodule
`default_nettype wire
